// File: rtl/axi4_burst_master_if.sv
// axi4_burst_master_if: command, user data streams and AXI4 master channels of the burst master
interface axi4_burst_master_if #(
  parameter int G_ADDR_WIDTH = 6,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_ID_WIDTH   = 2
);
  logic                      cmd_valid, cmd_ready, cmd_write;
  logic [G_ADDR_WIDTH-1:0]   cmd_addr;
  logic [7:0]                cmd_len;
  logic [G_ID_WIDTH-1:0]     cmd_id;
  logic                      wr_valid, wr_ready;
  logic [G_DATA_WIDTH-1:0]   wr_data;
  logic                      rd_valid, rd_ready, rd_last;
  logic [G_DATA_WIDTH-1:0]   rd_data;
  logic                      done;
  logic [1:0]                done_resp;
  logic [G_ID_WIDTH-1:0]     m_awid, m_wid, m_bid, m_arid, m_rid;
  logic [G_ADDR_WIDTH-1:0]   m_awaddr, m_araddr;
  logic [7:0]                m_awlen, m_arlen;
  logic [2:0]                m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]                m_awburst, m_arburst, m_bresp, m_rresp;
  logic                      m_awlock, m_arlock;
  logic [3:0]                m_awcache, m_arcache, m_awqos, m_arqos;
  logic                      m_awvalid, m_awready, m_arvalid, m_arready;
  logic [G_DATA_WIDTH-1:0]   m_wdata, m_rdata;
  logic [G_DATA_WIDTH/8-1:0] m_wstrb;
  logic                      m_wlast, m_wvalid, m_wready;
  logic                      m_bvalid, m_bready;
  logic                      m_rlast, m_rvalid, m_rready;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, done_resp,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos, m_awvalid,
    input  m_awready,
    output m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_arvalid,
    input  m_arready,
    input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, done_resp,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos, m_awvalid,
    output m_awready,
    input  m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_arvalid,
    output m_arready,
    output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: single-outstanding AXI4 INCR burst master; data channels pass straight through,
// burst end is counted internally so m_rlast is never trusted.
module axi4_burst_master #(
  parameter int G_ADDR_WIDTH = 6,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_ID_WIDTH   = 2
) (
  input logic clk_i,
  input logic resetn_i,
  axi4_burst_master_if.master bus
);
  localparam logic [2:0] SIZE = 3'($clog2(G_DATA_WIDTH / 8));
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;
  state_e                  state_q;
  logic [G_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]              len_q, cnt_q;
  logic [G_ID_WIDTH-1:0]   id_q;
  logic [1:0]              resp_q;
  logic                    cmd_ready_q, awvalid_q, arvalid_q, bready_q;
  logic                    in_w, in_r, in_b, w_hs, r_hs, last;
  logic                    unused_in;
  assign in_w = state_q == W;
  assign in_r = state_q == R;
  assign in_b = state_q == B;
  assign last = cnt_q == len_q;
  assign w_hs = in_w & bus.wr_valid & bus.m_wready;
  assign r_hs = in_r & bus.m_rvalid & bus.rd_ready;
  assign unused_in = ^{bus.m_bid, bus.m_rid, bus.m_rlast};
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          addr_q      <= bus.cmd_addr;
          len_q       <= bus.cmd_len;
          id_q        <= bus.cmd_id;
          cnt_q       <= '0;
          resp_q      <= '0;
          cmd_ready_q <= 1'b0;
          awvalid_q   <= bus.cmd_write;
          arvalid_q   <= !bus.cmd_write;
          state_q     <= bus.cmd_write ? AW : AR;
        end
        AW: if (bus.m_awready) begin
          awvalid_q <= 1'b0;
          state_q   <= W;
        end
        W: if (w_hs) begin
          cnt_q <= cnt_q + 8'd1;
          if (last) begin
            bready_q <= 1'b1;
            state_q  <= B;
          end
        end
        B: if (bus.m_bvalid) begin
          bready_q    <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        AR: if (bus.m_arready) begin
          arvalid_q <= 1'b0;
          state_q   <= R;
        end
        R: if (r_hs) begin
          cnt_q  <= cnt_q + 8'd1;
          resp_q <= resp_q | bus.m_rresp;
          if (last) begin
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          cmd_ready_q <= 1'b1;
          awvalid_q   <= 1'b0;
          arvalid_q   <= 1'b0;
          bready_q    <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.m_awid    = id_q;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awlen   = len_q;
  assign bus.m_awsize  = SIZE;
  assign bus.m_awburst = 2'b01;
  assign bus.m_awlock  = 1'b0;
  assign bus.m_awcache = '0;
  assign bus.m_awprot  = '0;
  assign bus.m_awqos   = '0;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_arid    = id_q;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arlen   = len_q;
  assign bus.m_arsize  = SIZE;
  assign bus.m_arburst = 2'b01;
  assign bus.m_arlock  = 1'b0;
  assign bus.m_arcache = '0;
  assign bus.m_arprot  = '0;
  assign bus.m_arqos   = '0;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_wid     = id_q;
  assign bus.m_wdata   = bus.wr_data;
  assign bus.m_wstrb   = '1;
  assign bus.m_wlast   = in_w & last;
  assign bus.m_wvalid  = in_w & bus.wr_valid;
  assign bus.wr_ready  = in_w & bus.m_wready;
  assign bus.m_bready  = bready_q;
  assign bus.rd_valid  = in_r & bus.m_rvalid;
  assign bus.m_rready  = in_r & bus.rd_ready;
  assign bus.rd_data   = bus.m_rdata;
  assign bus.rd_last   = in_r & last;
  // read responses include the current beat so the final done_resp covers every beat
  assign bus.done      = (in_b & bus.m_bvalid) | (r_hs & last);
  assign bus.done_resp = in_b ? bus.m_bresp : resp_q | bus.m_rresp;
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: transaction-level model plus 16-word AXI slave checking the burst master
module tb_axi4_burst_master;
  localparam int PI = 0, PAW = 1, PW = 2, PB = 3, PAR = 4, PR = 5;
  typedef struct packed {logic wr; logic [5:0] addr; logic [7:0] len; logic [1:0] id;} cmd_t;
  logic clk, resetn;
  axi4_burst_master_if bus ();
  axi4_burst_master dut (.clk_i(clk), .resetn_i(resetn), .bus(bus));
  int checks = 0, errors = 0;
  cmd_t mcmdq[$], dcmdq[$], cur;
  logic [31:0] wq[$], exp_w[$], rd_log[$];
  logic [1:0] done_log[$];
  logic [31:0] ref_mem[16], smem[16];
  logic [1:0] rresp_cfg[256], bresp_cfg, exp_resp, m_resp;
  int ph, beat, done_cnt, w_beats;
  logic m_done;
  logic [3:0] s_wbase, s_wi, s_rbase;
  logic [7:0] s_ri, s_rlen;
  bit s_ract, s_bpend, aw_seen, ar_seen, s_aw_hs, s_ar_hs, wphase, rphase, wv_toggle, rr_toggle;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(logic wr, logic [5:0] a, logic [7:0] l, logic [1:0] id);
    cmd_t c;
    c = '{wr, a, l, id};
    mcmdq.push_back(c);
    dcmdq.push_back(c);
  endtask

  task automatic push_w(logic [31:0] d);
    wq.push_back(d);
    exp_w.push_back(d);
  endtask

  task automatic wait_done(int n, int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt < start + n; i++) @(posedge clk);
    chk("done_count", done_cnt - start, n);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // model and slave state advance at the negedge, on the handshakes the next posedge will take
  always @(negedge clk) begin
    if (!resetn) begin
      ph = PI; beat = 0;
      mcmdq.delete(); dcmdq.delete(); wq.delete(); exp_w.delete();
      s_ract = 0; s_bpend = 0; aw_seen = 0; ar_seen = 0; s_aw_hs = 0; s_ar_hs = 0;
    end else begin
      chk("cmd_ready", bus.cmd_ready, ph == PI);
      chk("awvalid", bus.m_awvalid, ph == PAW);
      chk("arvalid", bus.m_arvalid, ph == PAR);
      chk("bready", bus.m_bready, ph == PB);
      chk("wvalid", bus.m_wvalid, ph == PW && bus.wr_valid);
      chk("wr_ready", bus.wr_ready, ph == PW && bus.m_wready);
      chk("rd_valid", bus.rd_valid, ph == PR && bus.m_rvalid);
      chk("rready", bus.m_rready, ph == PR && bus.rd_ready);
      m_done = (ph == PB && bus.m_bvalid) || (ph == PR && bus.m_rvalid && bus.rd_ready && beat == int'(cur.len));
      m_resp = ph == PB ? bresp_cfg : exp_resp | bus.m_rresp;
      chk("done", bus.done, m_done);
      if (m_done) chk("done_resp", bus.done_resp, m_resp);
      if (ph == PAW && bus.m_awready) begin
        chk("awaddr", bus.m_awaddr, cur.addr);
        chk("awlen", bus.m_awlen, cur.len);
        chk("awid", bus.m_awid, cur.id);
        chk("aw_const", {bus.m_awsize, bus.m_awburst, bus.m_awlock, bus.m_awcache, bus.m_awprot, bus.m_awqos}, {3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});
      end
      if (ph == PAR && bus.m_arready) begin
        chk("araddr", bus.m_araddr, cur.addr);
        chk("arlen", bus.m_arlen, cur.len);
        chk("arid", bus.m_arid, cur.id);
        chk("ar_const", {bus.m_arsize, bus.m_arburst, bus.m_arlock, bus.m_arcache, bus.m_arprot, bus.m_arqos}, {3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});
      end
      if (ph == PW && bus.wr_valid && bus.m_wready && exp_w.size() > 0) begin
        chk("wdata", bus.m_wdata, exp_w[0]);
        chk("wlast", bus.m_wlast, beat == int'(cur.len));
        chk("wid", bus.m_wid, cur.id);
        chk("wstrb", bus.m_wstrb, 4'hF);
      end
      if (ph == PR && bus.m_rvalid && bus.rd_ready) begin
        chk("rd_data", bus.rd_data, ref_mem[cur.addr[5:2] + 4'(beat)]);
        chk("rd_last", bus.rd_last, beat == int'(cur.len));
      end
      case (ph)
        PI: if (bus.cmd_valid && mcmdq.size() > 0) begin
          cur = mcmdq.pop_front(); beat = 0; exp_resp = 0;
          ph = cur.wr ? PAW : PAR;
        end
        PAW: if (bus.m_awready) ph = PW;
        PW: if (bus.wr_valid && bus.m_wready && exp_w.size() > 0) begin
          ref_mem[cur.addr[5:2] + 4'(beat)] = exp_w.pop_front();
          if (beat == int'(cur.len)) ph = PB; else beat++;
        end
        PB: if (bus.m_bvalid) ph = PI;
        PAR: if (bus.m_arready) ph = PR;
        PR: if (bus.m_rvalid && bus.rd_ready) begin
          exp_resp = exp_resp | bus.m_rresp;
          if (beat == int'(cur.len)) ph = PI; else beat++;
        end
        default: ph = PI;
      endcase
      if (bus.cmd_valid && bus.cmd_ready && dcmdq.size() > 0) void'(dcmdq.pop_front());
      if (bus.wr_valid && bus.wr_ready && wq.size() > 0) void'(wq.pop_front());
      if (bus.m_awvalid && bus.m_awready) begin s_wbase = bus.m_awaddr[5:2]; s_wi = 0; s_aw_hs = 1; end
      if (bus.m_wvalid && bus.m_wready) begin
        smem[s_wbase + s_wi] = bus.m_wdata; s_wi++; w_beats++;
        if (bus.m_wlast) s_bpend = 1;
      end
      if (bus.m_bvalid && bus.m_bready) s_bpend = 0;
      if (bus.m_arvalid && bus.m_arready) begin s_rbase = bus.m_araddr[5:2]; s_rlen = bus.m_arlen; s_ri = 0; s_ract = 1; s_ar_hs = 1; end
      if (bus.m_rvalid && bus.m_rready) begin
        if (s_ri == s_rlen) s_ract = 0; else s_ri++;
      end
      if (bus.rd_valid && bus.rd_ready) rd_log.push_back(bus.rd_data);
      if (bus.done) begin done_log.push_back(bus.done_resp); done_cnt++; end
    end
  end

  always @(posedge clk) begin
    #1;
    wphase = !wphase; rphase = !rphase;
    if (!resetn) begin
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_len = 0; bus.cmd_id = 0;
      bus.wr_valid = 0; bus.wr_data = 0; bus.rd_ready = 0;
      bus.m_awready = 0; bus.m_arready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0; bus.m_bid = 0;
      bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0; bus.m_rlast = 0; bus.m_rid = 0;
    end else begin
      bus.cmd_valid = dcmdq.size() > 0;
      {bus.cmd_write, bus.cmd_addr, bus.cmd_len, bus.cmd_id} = dcmdq.size() > 0 ? dcmdq[0] : '0;
      bus.wr_valid = wq.size() > 0 && (!wv_toggle || wphase);
      bus.wr_data = wq.size() > 0 ? wq[0] : 32'h0;
      bus.rd_ready = !rr_toggle || rphase;
      if (s_aw_hs) begin s_aw_hs = 0; aw_seen = 0; bus.m_awready = 0; end
      else begin bus.m_awready = aw_seen; aw_seen = bus.m_awvalid; end
      if (s_ar_hs) begin s_ar_hs = 0; ar_seen = 0; bus.m_arready = 0; end
      else begin bus.m_arready = ar_seen; ar_seen = bus.m_arvalid; end
      bus.m_wready = 1; bus.m_bvalid = s_bpend; bus.m_bresp = bresp_cfg; bus.m_bid = 0;
      bus.m_rvalid = s_ract; bus.m_rid = 0;
      bus.m_rdata = smem[s_rbase + s_ri[3:0]];
      bus.m_rresp = s_ract ? rresp_cfg[s_ri] : 2'b00;
      bus.m_rlast = s_ract && s_ri == s_rlen;
    end
  end

  initial begin
    int n0, d0;
    resetn = 0; bresp_cfg = 0; wv_toggle = 0; rr_toggle = 0; done_cnt = 0; w_beats = 0;
    s_wbase = 0; s_wi = 0; s_rbase = 0; s_ri = 0; s_rlen = 0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = 32'h1000 + i; smem[i] = 32'h1000 + i; end
    for (int i = 0; i < 256; i++) rresp_cfg[i] = 2'b00;
    repeat (2) @(posedge clk);
    #2 chk("rst_outs", {bus.m_awvalid, bus.m_arvalid, bus.m_wvalid, bus.m_bready, bus.m_rready, bus.wr_ready, bus.rd_valid, bus.done}, 8'h00);
    @(negedge clk);
    #2 resetn = 1;
    push_cmd(1, 6'h08, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) push_w(32'hA0 + i);
    wait_done(1, 50);
    #2 chk("idle_after_wr", bus.cmd_ready, 1);
    chk("wr_resp", done_log[done_log.size() - 1], 2'b00);
    n0 = rd_log.size();
    push_cmd(0, 6'h08, 8'd3, 2'd2);
    wait_done(1, 50);
    for (int i = 0; i < 4; i++) chk("readback_a", rd_log[n0 + i], 32'hA0 + i);
    push_cmd(0, 6'h00, 8'd0, 2'd0);
    wait_done(1, 50);
    #2 chk("idle_after_single", bus.cmd_ready, 1);
    chk("single_data", rd_log[rd_log.size() - 1], 32'h1000);
    wv_toggle = 1;
    push_cmd(1, 6'h20, 8'd3, 2'd3);
    for (int i = 0; i < 4; i++) push_w(32'hB0 + i);
    wait_done(1, 60);
    wv_toggle = 0; rr_toggle = 1; n0 = rd_log.size();
    push_cmd(0, 6'h20, 8'd3, 2'd1);
    wait_done(1, 60);
    rr_toggle = 0;
    chk("toggle_count", rd_log.size() - n0, 4);
    for (int i = 0; i < 4; i++) chk("readback_b", rd_log[n0 + i], 32'hB0 + i);
    push_cmd(1, 6'h30, 8'd1, 2'd0);
    push_cmd(1, 6'h38, 8'd1, 2'd2);
    push_w(32'hC0); push_w(32'hC1); push_w(32'hD0); push_w(32'hD1);
    wait_done(2, 80);
    n0 = rd_log.size();
    push_cmd(0, 6'h30, 8'd3, 2'd0);
    wait_done(1, 50);
    chk("b2b_0", rd_log[n0], 32'hC0);
    chk("b2b_1", rd_log[n0 + 1], 32'hC1);
    chk("b2b_2", rd_log[n0 + 2], 32'hD0);
    chk("b2b_3", rd_log[n0 + 3], 32'hD1);
    rresp_cfg[1] = 2'b10;
    push_cmd(0, 6'h10, 8'd2, 2'd1);
    wait_done(1, 50);
    rresp_cfg[1] = 2'b00;
    chk("sticky_rresp", done_log[done_log.size() - 1], 2'b10);
    bresp_cfg = 2'b11;
    push_cmd(1, 6'h3C, 8'd0, 2'd2);
    push_w(32'hE0);
    wait_done(1, 50);
    bresp_cfg = 2'b00;
    chk("bresp", done_log[done_log.size() - 1], 2'b11);
    n0 = rd_log.size();
    push_cmd(0, 6'h00, 8'd255, 2'd3);
    wait_done(1, 600);
    chk("len255_beats", rd_log.size() - n0, 256);
    chk("len255_last", rd_log[rd_log.size() - 1], 32'hE0);
    push_cmd(1, 6'h28, 8'd3, 2'd3);
    for (int i = 0; i < 4; i++) push_w(32'hF0 + i);
    n0 = w_beats;
    for (int i = 0; i < 50 && w_beats < n0 + 2; i++) @(posedge clk);
    #2 chk("pre_rst_wvalid", bus.m_wvalid, 1);
    d0 = done_cnt;
    resetn = 0;
    #1 chk("rst_wvalid", bus.m_wvalid, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_done", bus.done, 0);
    repeat (2) @(negedge clk);
    #2 resetn = 1;
    #1 chk("rel_cmd_ready", bus.cmd_ready, 1);
    repeat (3) @(posedge clk);
    chk("no_done_on_abort", done_cnt - d0, 0);
    push_cmd(0, 6'h08, 8'd0, 2'd0);
    wait_done(1, 50);
    chk("recover_data", rd_log[rd_log.size() - 1], 32'hA0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
